// File: rtl/ebc_arb_pkg.sv
// Shared constants and grant-decoding helpers for the EBC row request/grant path.
package ebc_arb_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_X_WIDTH = 3;
   localparam int DEF_CNT_W   = 2;
   localparam int DEF_DROP_W  = 16;

   // Index of the set bit in a one-hot vector (OR of indices; meaningful only when one-hot).
   function automatic logic [DEF_X_WIDTH-1:0] onehot_to_idx(input logic [DEF_WIDTH-1:0] oh);
      logic [DEF_X_WIDTH-1:0] idx;
      idx = '0;
      for (int i = 0; i < DEF_WIDTH; i++) begin
         if (oh[i]) begin
            idx = idx | DEF_X_WIDTH'(i);
         end
      end
      return idx;
   endfunction

   // True when exactly one bit is set.
   function automatic logic is_onehot(input logic [DEF_WIDTH-1:0] oh);
      logic [DEF_WIDTH-1:0] one_less;
      one_less = oh - {{(DEF_WIDTH-1){1'b0}}, 1'b1};
      return (oh != '0) && ((oh & one_less) == '0);
   endfunction

endpackage

// File: rtl/row_evt_counter.sv
// Per-row pending-event counter: saturating up on events, down on retired grants.
module row_evt_counter
   import ebc_arb_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nz_o,
   output logic             drop_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             nz_reg;

   // Next count: simultaneous inc and dec cancel, a full counter drops the new event.
   always_comb begin
      cnt_next = cnt_reg;
      drop_o   = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_reg == CNT_MAX) begin
            drop_o = 1'b1;
         end else begin
            cnt_next = cnt_reg + CNT_ONE;
         end
      end else if (dec_i && !inc_i) begin
         if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
         end
      end
   end

   // Count and its non-zero flag register together so the request tracks the count exactly.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cnt_reg <= '0;
         nz_reg  <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         nz_reg  <= (cnt_next != '0);
      end
   end

   assign cnt_o = cnt_reg;
   assign nz_o  = nz_reg;

endmodule

// File: rtl/row_req_source.sv
// Requester side of the row arbiter handshake: queues row events, retires them on legal grants,
// and reports dropped events and grant protocol violations.
module row_req_source
   import ebc_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int x_width = DEF_X_WIDTH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int DROP_W  = DEF_DROP_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic [WIDTH-1:0]  evt_i,
   input  logic [WIDTH-1:0]  gnt_i,
   input  logic [x_width-1:0] xadd_i,
   output logic [WIDTH-1:0]  req_o,
   output logic              busy_o,
   output logic              overflow_o,
   output logic [DROP_W-1:0] drop_cnt_o,
   output logic              err_o
);

   localparam int DNUM_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0]   cnt_all [WIDTH];
   logic [WIDTH-1:0]   drop_vec;
   logic [x_width-1:0] gnt_idx;
   logic               gnt_onehot;
   logic               gnt_ok;
   logic               legal;
   logic               grant_err;
   logic [DNUM_W-1:0]  drop_num;
   logic [DROP_W:0]    drop_sum;
   logic [DROP_W-1:0]  drop_cnt_next;
   logic [DROP_W-1:0]  drop_cnt_reg;
   logic               overflow_reg;
   logic               err_reg;

   // Grant is legal only if one-hot, aimed at a row that is requesting, and the index agrees.
   always_comb begin
      gnt_idx    = onehot_to_idx(gnt_i);
      gnt_onehot = is_onehot(gnt_i);
      gnt_ok     = gnt_onehot && (cnt_all[gnt_idx] != '0) && (xadd_i == gnt_idx);
      legal      = enable_i && gnt_ok;
      grant_err  = enable_i && (gnt_i != '0) && !gnt_ok;
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
         row_evt_counter #(
            .CNT_W(CNT_W)
         ) u_cnt (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .inc_i  (evt_i[gi]),
            .dec_i  (legal & gnt_i[gi]),
            .cnt_o  (cnt_all[gi]),
            .nz_o   (req_o[gi]),
            .drop_o (drop_vec[gi])
         );
      end
   endgenerate

   // Count rows dropping an event this edge and add them to the saturating total.
   always_comb begin
      drop_num = '0;
      for (int i = 0; i < WIDTH; i++) begin
         drop_num = drop_num + {{(DNUM_W-1){1'b0}}, drop_vec[i]};
      end
      drop_sum      = {1'b0, drop_cnt_reg} + {{(DROP_W+1-DNUM_W){1'b0}}, drop_num};
      drop_cnt_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
   end

   // Status registers: sticky error, per-cycle overflow pulse, dropped-event total.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         err_reg      <= 1'b0;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         err_reg      <= err_reg | grant_err;
         overflow_reg <= (drop_vec != '0);
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   assign busy_o     = |req_o;
   assign overflow_o = overflow_reg;
   assign drop_cnt_o = drop_cnt_reg;
   assign err_o      = err_reg;

endmodule

// File: tb/tb_row_req_source.sv
// Scoreboard bench for row_req_source: the driver queues hand-computed expectations per cycle,
// the monitor pops and compares them between clock edges.
module tb_row_req_source;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [7:0]  evt;
   logic [7:0]  gnt;
   logic [2:0]  xadd;
   logic [7:0]  req;
   logic        busy;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic        err;

   typedef struct {
      string       name;
      logic [7:0]  req;
      logic        ovf;
      logic [15:0] drop;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   row_req_source dut (
      .clk_i     (clk),
      .reset_i   (reset_n),
      .enable_i  (enable),
      .evt_i     (evt),
      .gnt_i     (gnt),
      .xadd_i    (xadd),
      .req_o     (req),
      .busy_o    (busy),
      .overflow_o(overflow),
      .drop_cnt_o(drop_cnt),
      .err_o     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string field, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", nm, field, act, expv);
      end
   endtask

   // Drive one cycle of stimulus, then queue what the outputs must be after that edge.
   task automatic step(input string nm, input logic rst_n, input logic en,
                       input logic [7:0] e_v, input logic [7:0] g, input logic [2:0] x,
                       input logic [7:0] e_req, input logic e_ovf, input logic [15:0] e_drop,
                       input logic e_err);
      exp_t e;
      reset_n = rst_n;
      enable  = en;
      evt     = e_v;
      gnt     = g;
      xadd    = x;
      @(posedge clk);
      e.name = nm;
      e.req  = e_req;
      e.ovf  = e_ovf;
      e.drop = e_drop;
      e.err  = e_err;
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: compare every queued expectation on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         txn++;
         chk(mon_e.name, "req", {8'h00, req}, {8'h00, mon_e.req});
         chk(mon_e.name, "busy", {15'h0, busy}, {15'h0, |mon_e.req});
         chk(mon_e.name, "ovf", {15'h0, overflow}, {15'h0, mon_e.ovf});
         chk(mon_e.name, "drop", drop_cnt, mon_e.drop);
         chk(mon_e.name, "err", {15'h0, err}, {15'h0, mon_e.err});
         $display("txn %0d %s req=%h busy=%b ovf=%b drop=%0d err=%b", txn, mon_e.name,
                  req, busy, overflow, drop_cnt, err);
      end
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int d;
      reset_n = 1'b0; enable = 1'b0; evt = '0; gnt = '0; xadd = '0;

      // 1: reset overrides events and grants
      step("rst0", 0, 1, 8'hFF, 8'h01, 3'd0, 8'h00, 0, 16'd0, 0);
      step("rst1", 0, 1, 8'hFF, 8'h01, 3'd0, 8'h00, 0, 16'd0, 0);

      // 2: multi-row events, then legal grants clear one row each
      step("evt93", 1, 0, 8'h93, 8'h00, 3'd0, 8'h93, 0, 16'd0, 0);
      step("g0",    1, 1, 8'h00, 8'h01, 3'd0, 8'h92, 0, 16'd0, 0);
      step("g1",    1, 1, 8'h00, 8'h02, 3'd1, 8'h90, 0, 16'd0, 0);
      step("g4",    1, 1, 8'h00, 8'h10, 3'd4, 8'h80, 0, 16'd0, 0);
      step("g7",    1, 1, 8'h00, 8'h80, 3'd7, 8'h00, 0, 16'd0, 0);

      // 3: fill row 5 to max, fourth event drops, three grants drain it
      step("e5a", 1, 0, 8'h20, 8'h00, 3'd0, 8'h20, 0, 16'd0, 0);
      step("e5b", 1, 0, 8'h20, 8'h00, 3'd0, 8'h20, 0, 16'd0, 0);
      step("e5c", 1, 0, 8'h20, 8'h00, 3'd0, 8'h20, 0, 16'd0, 0);
      step("e5d", 1, 0, 8'h20, 8'h00, 3'd0, 8'h20, 1, 16'd1, 0);
      step("g5a", 1, 1, 8'h00, 8'h20, 3'd5, 8'h20, 0, 16'd1, 0);
      step("g5b", 1, 1, 8'h00, 8'h20, 3'd5, 8'h20, 0, 16'd1, 0);
      step("g5c", 1, 1, 8'h00, 8'h20, 3'd5, 8'h00, 0, 16'd1, 0);

      // 4: same-cycle event and grant on row 2 nets to zero
      step("e2",    1, 0, 8'h04, 8'h00, 3'd0, 8'h04, 0, 16'd1, 0);
      step("e2g2",  1, 1, 8'h04, 8'h04, 3'd2, 8'h04, 0, 16'd1, 0);
      step("g2",    1, 1, 8'h00, 8'h04, 3'd2, 8'h00, 0, 16'd1, 0);

      // two rows saturate together: two drops in one edge
      step("e03a", 1, 0, 8'h03, 8'h00, 3'd0, 8'h03, 0, 16'd1, 0);
      step("e03b", 1, 0, 8'h03, 8'h00, 3'd0, 8'h03, 0, 16'd1, 0);
      step("e03c", 1, 0, 8'h03, 8'h00, 3'd0, 8'h03, 0, 16'd1, 0);
      step("e03d", 1, 0, 8'h03, 8'h00, 3'd0, 8'h03, 1, 16'd3, 0);

      // 5: illegal grants from clean reset
      step("rstA", 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 0, 16'd0, 0);
      step("eA",   1, 0, 8'h01, 8'h00, 3'd0, 8'h01, 0, 16'd0, 0);
      step("g03",  1, 1, 8'h00, 8'h03, 3'd0, 8'h01, 0, 16'd0, 1);
      step("rstB", 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 0, 16'd0, 0);
      step("eB",   1, 0, 8'h01, 8'h00, 3'd0, 8'h01, 0, 16'd0, 0);
      step("g08",  1, 1, 8'h00, 8'h08, 3'd3, 8'h01, 0, 16'd0, 1);
      step("rstC", 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 0, 16'd0, 0);
      step("eC",   1, 0, 8'h04, 8'h00, 3'd0, 8'h04, 0, 16'd0, 0);
      step("g04x", 1, 1, 8'h00, 8'h04, 3'd3, 8'h04, 0, 16'd0, 1);
      // same stimulus with enable low: ignored entirely
      step("rstD", 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 0, 16'd0, 0);
      step("eD",   1, 0, 8'h01, 8'h00, 3'd0, 8'h01, 0, 16'd0, 0);
      step("n03",  1, 0, 8'h00, 8'h03, 3'd0, 8'h01, 0, 16'd0, 0);
      step("n08",  1, 0, 8'h00, 8'h08, 3'd3, 8'h01, 0, 16'd0, 0);
      step("eD2",  1, 0, 8'h04, 8'h00, 3'd0, 8'h05, 0, 16'd0, 0);
      step("n04x", 1, 0, 8'h00, 8'h04, 3'd3, 8'h05, 0, 16'd0, 0);
      step("n0g",  1, 0, 8'h00, 8'h01, 3'd0, 8'h05, 0, 16'd0, 0);
      step("idle", 1, 1, 8'h00, 8'h00, 3'd5, 8'h05, 0, 16'd0, 0);

      // 6: build cnt0=2, cnt6=3, drop=5, err=1, then reset clears all
      step("rstE", 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 0, 16'd0, 0);
      step("e41a", 1, 0, 8'h41, 8'h00, 3'd0, 8'h41, 0, 16'd0, 0);
      step("e41b", 1, 0, 8'h41, 8'h00, 3'd0, 8'h41, 0, 16'd0, 0);
      step("e40",  1, 0, 8'h40, 8'h00, 3'd0, 8'h41, 0, 16'd0, 0);
      for (int k = 1; k <= 5; k++) begin
         step("e40d", 1, 0, 8'h40, 8'h00, 3'd0, 8'h41, 1, 16'(k), 0);
      end
      step("bad",  1, 1, 8'h00, 8'h02, 3'd1, 8'h41, 0, 16'd5, 1);
      step("rstF", 0, 1, 8'h40, 8'h40, 3'd6, 8'h00, 0, 16'd0, 0);
      step("e6",   1, 0, 8'h40, 8'h00, 3'd0, 8'h40, 0, 16'd0, 0);

      // drop counter saturation: eight drops per edge with every row full
      step("rstG", 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 0, 16'd0, 0);
      for (int k = 0; k < 3; k++) begin
         step("fill", 1, 0, 8'hFF, 8'h00, 3'd0, 8'hFF, 0, 16'd0, 0);
      end
      for (int k = 1; k <= 8193; k++) begin
         d = 8 * k;
         if (d > 65535) d = 65535;
         step("sat", 1, 0, 8'hFF, 8'h00, 3'd0, 8'hFF, 1, 16'(d), 0);
      end
      step("satq", 1, 0, 8'h00, 8'h00, 3'd0, 8'hFF, 0, 16'hFFFF, 0);

      // drain the scoreboard with a bounded wait
      for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
         @(negedge clk);
      end
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
